sev_seg_scanner: RTL
====================

Name: sev_seg_scanner

Overview:
- Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display.
- Holds a 16-bit, four-nibble display value and cycles the anodes one digit at a time. Feeds each digit's nibble through a hex-to-segment decoder.
- Inserts an all-off blanking gap between digits to suppress ghosting.
- Value updates are double-buffered and applied only at frame boundaries, so a displayed frame never tears.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot, BLANK plus SHOW; 1 kHz per digit at 100 MHz. Legal when REFRESH_DIV > BLANK_CYC.
- BLANK_CYC, 1000: cycles per slot with all anodes off. Legal when BLANK_CYC >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- load  in  1  one-cycle strobe; captures digits_in, dp_in and en_in
- digits_in  in  16  nibble k = digits_in[4k+3:4k] drives digit k; digit 0 is rightmost
- dp_in  in  4  decimal point per digit, 1 = lit
- en_in  in  4  digit enable, 1 = digit shown
- seg_cat  out  8  cathodes, active low; [6:0] = {g,f,e,d,c,b,a}, [7] = dp
- seg_an  out  4  anodes, active low; seg_an[k] selects digit k
- update_ack  out  1  one-cycle pulse when pending data becomes active
- frame_done  out  1  one-cycle pulse at the end of digit 3's SHOW slot

Behaviour:
- Interface: one clock domain (clk); reset is asynchronous and active-high (rst). Reset asserts immediately and releases on the clk edge.
- Reset values:
  - seg_an = 4'b1111, seg_cat = 8'hFF, update_ack = 0, frame_done = 0.
  - Active and pending registers = 0, pending flag = 0.
  - State = BLANK, digit index = 0, slot counter = 0.
- States:
  - BLANK: seg_an = 1111 and seg_cat = FF. Lasts exactly BLANK_CYC cycles.
  - SHOW: seg_an is one-hot-low at the current index. seg_cat = decode(active nibble) with dp applied. Lasts REFRESH_DIV - BLANK_CYC cycles.
- Transitions:
  - BLANK -> SHOW with the same index.
  - SHOW -> BLANK with index+1 mod 4; index 3 wraps to 0.
- Slot counter runs 0..REFRESH_DIV-1 and resets at each slot end. State changes when the counter reaches BLANK_CYC-1 in BLANK, or REFRESH_DIV-1 in SHOW.
- All outputs are registered. seg_an and seg_cat change on the same edge as the state change, so there is no cycle of a mismatched anode/cathode pair.
- Disabled digit (active en[k] = 0): the slot is still spent, but seg_an stays 1111 for its SHOW period. Slot timing is unchanged.
- Frame boundary: the edge where SHOW index 3 -> BLANK index 0.
  - frame_done pulses during the last SHOW cycle of digit 3.
  - If the pending flag is set, the boundary edge copies pending to active, clears the flag, and pulses update_ack the following cycle.
- load:
  - Captures into pending and sets the pending flag.
  - A later load before the boundary overwrites pending (last write wins).
  - load in the boundary cycle: the new inputs go straight to active, bypassing pending; update_ack pulses.
- Reset mid-frame: immediate blank. After release, the scan restarts at BLANK index 0 and pending data is lost.
- Decoder: full hex 0-F. The patterns are the board standard: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=A7, d=A1, E=86, F=8E. These values are the low 7 bits; bit7 = ~dp.

Optional Feature:
- Macro: SEV_SEG_LEAD_ZERO_BLANK_EN.
- Defined:
  - In SHOW, digit k (k = 3..1) is blanked (seg_an = 1111) when its active nibble is 0 and all higher-index nibbles are 0.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - Suppression is evaluated on the active register only.
- Undefined: all enabled digits are shown, including leading zeros. No extra logic is built.

Decomposition:
- Package sev_seg_pkg:
  - State encoding (ST_BLANK, ST_SHOW).
  - SEG_OFF = 8'hFF and AN_OFF = 4'b1111.
  - 16-entry hex-to-segment constant table.
- Sub-module seg_hex_decode: combinational 4-bit to 7-bit active-low decoder, instantiated once and driven by the muxed nibble.

Test Plan:
- Use REFRESH_DIV=8, BLANK_CYC=2 throughout.
- Reset, then load digits_in=16'h1234, en_in=F, dp_in=0 -> update_ack at the first boundary. Next frame: digit 0 shows seg_an=1110 with seg_cat=0x99 for 6 cycles, after 2 blank cycles. Digits 1/2/3 then show B0/A4/F9.
- Two loads (16'h1111, then 16'h2222) within one frame -> exactly one update_ack; the next frame shows only "2" patterns (A4). The bypass case: load asserted in the frame_done cycle takes effect without a frame delay.
- en_in=4'b0101, dp_in=4'b0001 -> seg_an stays 1111 in the digit 1 and 3 SHOW slots. Digit 0 seg_cat has bit7=0. frame_done period remains 32 cycles.
- Assert rst mid-SHOW of digit 2 -> seg_an=1111 and seg_cat=FF in the same cycle, before the next edge. After release, BLANK for 2 cycles, then digit 0; the pre-reset pending load is not applied.
- With SEV_SEG_LEAD_ZERO_BLANK_EN, load 16'h0070 -> digits 3 and 2 blanked; digit 1 shows F8 and digit 0 shows C0. Load 16'h0000 -> only digit 0 lit, showing C0. Without the macro, all four digits are lit.

Source files
------------

// File: rtl/sev_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sev_seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Active-low {g,f,e,d,c,b,a} patterns, entry n is hex digit n
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h27,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decode
    import sev_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    // Table lookup of the board-standard glyphs
    always_comb begin
        seg_c = HEX_SEG[nibble];
    end

endmodule

// File: rtl/sev_seg_scanner.sv
// Four-digit common-anode seven-segment scan controller with blanking gaps
// and frame-aligned double-buffered updates.
// Optional: define SEV_SEG_LEAD_ZERO_BLANK_EN to suppress leading zeros.
module sev_seg_scanner
    import sev_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  en_in,
    output logic [7:0]  seg_cat,
    output logic [3:0]  seg_an,
    output logic        update_ack,
    output logic        frame_done
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

    state_t           state;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;

    logic [15:0] act_digits;
    logic [3:0]  act_dp;
    logic [3:0]  act_en;
    logic [15:0] pend_digits;
    logic [3:0]  pend_dp;
    logic [3:0]  pend_en;
    logic        pend_flag;

    logic             last_c;
    logic             boundary_c;
    state_t           state_n_c;
    logic [1:0]       idx_n_c;
    logic [CNT_W-1:0] cnt_n_c;
    logic [15:0]      act_digits_n_c;
    logic [3:0]       act_dp_n_c;
    logic [3:0]       act_en_n_c;
    logic [3:0]       nibble_c;
    logic [6:0]       seg7_c;
    logic             lit_c;

    // Slot sequencing lookahead: where the scan will be after this edge
    always_comb begin
        state_n_c = state;
        idx_n_c   = idx;
        cnt_n_c   = cnt + CNT_W'(1);
        last_c    = (state == ST_BLANK) ? (cnt == BLANK_LAST) : (cnt == SLOT_LAST);
        if (last_c) begin
            if (state == ST_BLANK) begin
                state_n_c = ST_SHOW;
            end else begin
                state_n_c = ST_BLANK;
                idx_n_c   = idx + 2'd1;
                cnt_n_c   = '0;
            end
        end
        boundary_c = (state == ST_SHOW) && (idx == 2'd3) && last_c;
    end

    // Active data after this edge: load bypasses pending at the boundary
    always_comb begin
        act_digits_n_c = act_digits;
        act_dp_n_c     = act_dp;
        act_en_n_c     = act_en;
        if (boundary_c && load) begin
            act_digits_n_c = digits_in;
            act_dp_n_c     = dp_in;
            act_en_n_c     = en_in;
        end else if (boundary_c && pend_flag) begin
            act_digits_n_c = pend_digits;
            act_dp_n_c     = pend_dp;
            act_en_n_c     = pend_en;
        end
        nibble_c = act_digits_n_c[4*idx_n_c +: 4];
    end

    seg_hex_decode u_dec (
        .nibble (nibble_c),
        .seg_c  (seg7_c)
    );

`ifdef SEV_SEG_LEAD_ZERO_BLANK_EN
    logic [3:0] lead_zero_c;

    // Digit lit when enabled and not a leading zero; digit 0 always eligible
    always_comb begin
        lead_zero_c[3] = (act_digits_n_c[15:12] == 4'h0);
        lead_zero_c[2] = lead_zero_c[3] && (act_digits_n_c[11:8] == 4'h0);
        lead_zero_c[1] = lead_zero_c[2] && (act_digits_n_c[7:4] == 4'h0);
        lead_zero_c[0] = 1'b0;
        lit_c = act_en_n_c[idx_n_c] && !lead_zero_c[idx_n_c];
    end
`else
    // Digit lit when enabled
    always_comb begin
        lit_c = act_en_n_c[idx_n_c];
    end
`endif

    // Scan FSM with outputs registered from the lookahead so anode and cathode move together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_BLANK;
            idx        <= 2'd0;
            cnt        <= '0;
            seg_an     <= AN_OFF;
            seg_cat    <= SEG_OFF;
            update_ack <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n_c;
            idx        <= idx_n_c;
            cnt        <= cnt_n_c;
            update_ack <= boundary_c && (pend_flag || load);
            frame_done <= (state_n_c == ST_SHOW) && (idx_n_c == 2'd3) && (cnt_n_c == SLOT_LAST);
            if ((state_n_c == ST_SHOW) && lit_c) begin
                seg_an  <= ~(4'b0001 << idx_n_c);
                seg_cat <= {~act_dp_n_c[idx_n_c], seg7_c};
            end else begin
                seg_an  <= AN_OFF;
                seg_cat <= SEG_OFF;
            end
        end
    end

    // Active and pending display buffers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_digits  <= '0;
            act_dp      <= '0;
            act_en      <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_en     <= '0;
            pend_flag   <= 1'b0;
        end else begin
            act_digits <= act_digits_n_c;
            act_dp     <= act_dp_n_c;
            act_en     <= act_en_n_c;
            if (load && !boundary_c) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_en     <= en_in;
                pend_flag   <= 1'b1;
            end else if (boundary_c) begin
                pend_flag   <= 1'b0;
            end
        end
    end

endmodule
